// File: rtl/icache.sv
// icache: direct-mapped one-word-line instruction cache with miss fill and flush-safe discard
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        enable_from_fetcher,
  input  logic [31:0] address_from_fetcher,
  output logic        end_to_fetcher,
  output logic [31:0] inst_to_fetcher,
  output logic        enable_to_memctrl,
  output logic [31:0] address_to_memctrl,
  input  logic        end_from_memctrl,
  input  logic [31:0] inst_from_memctrl
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;
  typedef enum logic [1:0] {IDLE, MISS, MISS_DISCARD} state_t;
  state_t state, state_n;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0] data [LINES];
  logic [31:0] req_addr;
  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_BITS-1:0] req_tag, fill_tag;
  logic hit, accept, fill, respond_hit, respond_fill, start_miss;
  logic end_n, en_n;
  logic [31:0] inst_n, addr_n;
  assign req_addr = address_from_fetcher & 32'hFFFF_FFFC;
  assign req_idx = req_addr[INDEX_BITS+1:2];
  assign req_tag = req_addr[31:INDEX_BITS+2];
  assign fill_idx = address_to_memctrl[INDEX_BITS+1:2];
  assign fill_tag = address_to_memctrl[31:INDEX_BITS+2];
  assign hit = valid[req_idx] && tags[req_idx] == req_tag;
  assign accept = state == IDLE && enable_from_fetcher && !end_to_fetcher && !clear_in;
  assign fill = state != IDLE && end_from_memctrl;
  assign respond_hit = accept && hit;
  assign start_miss = accept && !hit;
  assign respond_fill = state == MISS && fill && !clear_in;
  // state register; a stalled cycle leaves everything untouched
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else if (rdy_in) state <= state_n;
  end
  // next state: a clear during a miss keeps the transfer alive but drops the reply
  always_comb begin
    state_n = state == IDLE ? (start_miss ? MISS : IDLE)
            : fill ? IDLE
            : (state == MISS && clear_in) ? MISS_DISCARD : state;
  end
  // next output values; the fill request stays up until the memory controller ends it
  always_comb begin
    end_n = respond_hit || respond_fill;
    inst_n = respond_hit ? data[req_idx] : respond_fill ? inst_from_memctrl : inst_to_fetcher;
    en_n = state == IDLE ? start_miss : !fill;
    addr_n = start_miss ? req_addr : address_to_memctrl;
  end
  // registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      end_to_fetcher <= 1'b0;
      inst_to_fetcher <= '0;
      enable_to_memctrl <= 1'b0;
      address_to_memctrl <= '0;
    end else if (rdy_in) begin
      end_to_fetcher <= end_n;
      inst_to_fetcher <= inst_n;
      enable_to_memctrl <= en_n;
      address_to_memctrl <= addr_n;
    end
  end
  // valid bits: only reset clears them, any completed fill sets the indexed one
  always_ff @(posedge clk_in) begin
    if (rst_in) valid <= '0;
    else if (rdy_in && fill) valid[fill_idx] <= 1'b1;
  end
  // tag and data arrays: unconditional overwrite of the indexed line on fill
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= inst_from_memctrl;
    end
  end
endmodule

// File: tb/tb_icache.sv
// tb_icache: vector table, directed reset cases and randomized traffic against a line-level cache model
module tb_icache;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0, rdy_in = 1'b1, clear_in = 1'b0, enable_from_fetcher = 1'b0, end_from_memctrl = 1'b0;
  logic [31:0] address_from_fetcher = '0, inst_from_memctrl = '0;
  logic end_to_fetcher, enable_to_memctrl;
  logic [31:0] inst_to_fetcher, address_to_memctrl;
  int total = 0, bad = 0;
  bit mvalid [64];
  logic [29:0] mword [64];
  logic [31:0] mdata [64];
  typedef struct {
    logic [31:0] addr;
    int lat;
    int clr_at;
    int stall_at;
    logic [31:0] fill;
    bit miss;
    bit pulse;
    logic [31:0] data;
    int cyc;
  } vec_t;
  vec_t vecs [10];

  icache #(.INDEX_BITS(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .enable_from_fetcher(enable_from_fetcher), .address_from_fetcher(address_from_fetcher),
    .end_to_fetcher(end_to_fetcher), .inst_to_fetcher(inst_to_fetcher),
    .enable_to_memctrl(enable_to_memctrl), .address_to_memctrl(address_to_memctrl),
    .end_from_memctrl(end_from_memctrl), .inst_from_memctrl(inst_from_memctrl)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1; rdy_in = 1; clear_in = 0; enable_from_fetcher = 0; end_from_memctrl = 0;
    @(negedge clk_in);
    rst_in = 0;
    for (int i = 0; i < 64; i++) mvalid[i] = 0;
  endtask

  task automatic fetch(input logic [31:0] a, input int lat, input int clr_at, input int stall_at,
                       input logic [31:0] fill, output bit miss, output bit pulse,
                       output logic [31:0] data, output int pcyc, output int vis,
                       output logic [31:0] maddr, output bit stable);
    int cnt;
    bit cleared, done;
    cnt = 0; done = 0;
    miss = 0; pulse = 0; data = 0; pcyc = 0; vis = 0; maddr = 0; stable = 1;
    @(negedge clk_in);
    enable_from_fetcher = 1; address_from_fetcher = a;
    clear_in = (clr_at == 0); cleared = (clr_at == 0);
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk_in);
      clear_in = 0; end_from_memctrl = 0;
      if (cleared) enable_from_fetcher = 0;
      rdy_in = !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + 3);
      if (end_to_fetcher) begin
        pulse = 1; data = inst_to_fetcher; pcyc = cyc; done = 1;
      end else if (enable_to_memctrl) begin
        if (!miss) maddr = address_to_memctrl;
        else if (address_to_memctrl !== maddr) stable = 0;
        miss = 1; vis++;
        if (rdy_in) begin
          cnt++;
          if (cnt == lat) begin end_from_memctrl = 1; inst_from_memctrl = fill; end
        end
      end else if (miss || cyc >= 3) done = 1;
      if (!done && cyc == clr_at) begin clear_in = 1; cleared = 1; end
    end
    chk("fetch_done", done, 1);
    enable_from_fetcher = 0; rdy_in = 1; end_from_memctrl = 0; clear_in = 0;
    @(negedge clk_in);
    chk("no_back_to_back", end_to_fetcher, 0);
  endtask

  task automatic apply(input string name, input vec_t v);
    bit miss, pulse, stable;
    logic [31:0] data, maddr;
    int pcyc, vis;
    fetch(v.addr, v.lat, v.clr_at, v.stall_at, v.fill, miss, pulse, data, pcyc, vis, maddr, stable);
    chk({name, "_miss"}, miss, v.miss);
    chk({name, "_pulse"}, pulse, v.pulse);
    if (v.pulse) begin
      chk({name, "_data"}, data, v.data);
      chk({name, "_latency"}, pcyc, v.cyc);
    end
    if (v.miss) begin
      chk({name, "_memaddr"}, maddr, {v.addr[31:2], 2'b00});
      chk({name, "_req_cycles"}, vis, v.lat + (v.stall_at > 0 ? 3 : 0));
      chk({name, "_req_stable"}, stable, 1);
      mvalid[v.addr[7:2]] = 1;
      mword[v.addr[7:2]] = v.addr[31:2];
      mdata[v.addr[7:2]] = v.fill;
    end
  endtask

  function automatic vec_t predict(input logic [31:0] a, input int lat, input int clr_at,
                                   input int stall_at, input logic [31:0] fill);
    vec_t v;
    bit hit;
    hit = mvalid[a[7:2]] && mword[a[7:2]] == a[31:2];
    v.addr = a; v.lat = lat; v.clr_at = clr_at; v.stall_at = stall_at; v.fill = fill;
    v.miss = clr_at != 0 && !hit;
    v.pulse = clr_at != 0 && (hit || clr_at < 0 || clr_at > lat);
    v.data = hit ? mdata[a[7:2]] : fill;
    v.cyc = hit ? 1 : lat + 1 + (stall_at > 0 ? 3 : 0);
    return v;
  endfunction

  initial begin
    vecs[0] = '{32'h0000_1000, 5, -1, 0, 32'h0000_0013, 1, 1, 32'h0000_0013, 6};
    vecs[1] = '{32'h0000_1000, 1, -1, 0, 32'h0,        0, 1, 32'h0000_0013, 1};
    vecs[2] = '{32'h0000_1100, 3, -1, 0, 32'hAAAA_0001, 1, 1, 32'hAAAA_0001, 4};
    vecs[3] = '{32'h0000_1000, 2, -1, 0, 32'h0000_0013, 1, 1, 32'h0000_0013, 3};
    vecs[4] = '{32'h0000_2004, 4, 2, 0, 32'hBEEF_0004, 1, 0, 32'h0, 0};
    vecs[5] = '{32'h0000_2007, 1, -1, 0, 32'h0,        0, 1, 32'hBEEF_0004, 1};
    vecs[6] = '{32'h0000_2004, 1, 0, 0, 32'h0,         0, 0, 32'h0, 0};
    vecs[7] = '{32'h0000_3008, 1, 1, 0, 32'h1111_0008, 1, 0, 32'h0, 0};
    vecs[8] = '{32'h0000_3008, 1, -1, 0, 32'h0,        0, 1, 32'h1111_0008, 1};
    vecs[9] = '{32'h0000_400C, 4, -1, 2, 32'h400C_0001, 1, 1, 32'h400C_0001, 8};
    do_reset();
    chk("rst_end", end_to_fetcher, 0);
    chk("rst_inst", inst_to_fetcher, 0);
    chk("rst_en", enable_to_memctrl, 0);
    chk("rst_addr", address_to_memctrl, 0);
    for (int i = 0; i < 10; i++) apply($sformatf("vec%0d", i), vecs[i]);
    do_reset();
    apply("after_reset", '{32'h0000_1000, 2, -1, 0, 32'h0000_0013, 1, 1, 32'h0000_0013, 3});
    @(negedge clk_in);
    enable_from_fetcher = 1; address_from_fetcher = 32'h0000_5010;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("midmiss_en", enable_to_memctrl, 1);
    rst_in = 1; enable_from_fetcher = 0; end_from_memctrl = 1; inst_from_memctrl = 32'hDEAD_0000;
    @(negedge clk_in);
    rst_in = 0; end_from_memctrl = 0;
    chk("midmiss_rst_en", enable_to_memctrl, 0);
    chk("midmiss_rst_end", end_to_fetcher, 0);
    chk("midmiss_rst_addr", address_to_memctrl, 0);
    for (int i = 0; i < 64; i++) mvalid[i] = 0;
    apply("midmiss_refetch", '{32'h0000_5010, 1, -1, 0, 32'h5010_0001, 1, 1, 32'h5010_0001, 2});
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a, fill;
      int lat, clr_at, stall_at, r;
      vec_t v;
      if ($urandom_range(0, 39) == 0) do_reset();
      a = 32'h0001_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      lat = $urandom_range(1, 4);
      fill = $urandom;
      r = $urandom_range(0, 5);
      clr_at = r == 0 ? 0 : r == 1 ? $urandom_range(1, lat + 1) : -1;
      stall_at = 0;
      v = predict(a, lat, clr_at, stall_at, fill);
      if (clr_at < 0 && v.miss && $urandom_range(0, 3) == 0) begin
        stall_at = $urandom_range(1, lat);
        v = predict(a, lat, clr_at, stall_at, fill);
      end
      apply("rand", v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 6, line-index width (2^INDEX_BITS one-word lines, direct-mapped).
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 rdy_in  input  1  global enable; low freezes all state and outputs.
REQ-005 clear_in  input  1  pipeline flush; cancel current fetch request.
REQ-006 enable_from_fetcher  input  1  fetch request valid; held with address until end_to_fetcher.
REQ-007 address_from_fetcher  input  32  fetch PC; bits [1:0] ignored.
REQ-008 end_to_fetcher  output  1  one-cycle pulse, inst_to_fetcher valid.
REQ-009 inst_to_fetcher  output  32  fetched instruction.
REQ-010 enable_to_memctrl  output  1  line-fill request to memory controller, held until end_from_memctrl.
REQ-011 address_to_memctrl  output  32  word-aligned fill address ([1:0]=0).
REQ-012 end_from_memctrl  input  1  one-cycle pulse, fill data valid.
REQ-013 inst_from_memctrl  input  32  fill data.

Function
REQ-014 Address split: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2]; per line: valid bit, tag, 32-bit data.
REQ-015 States: IDLE, MISS, MISS_DISCARD.
REQ-016 IDLE accepts a request only when enable_from_fetcher=1, end_to_fetcher=0, clear_in=0; max one request per two cycles.
REQ-017 Hit (valid and tag match) in IDLE: next cycle end_to_fetcher=1, inst_to_fetcher=line data; latency 1; state stays IDLE.
REQ-018 Miss in IDLE: next cycle enable_to_memctrl=1, address_to_memctrl={addr[31:2],2'b00}; state -> MISS.
REQ-019 MISS: hold enable_to_memctrl and address stable until end_from_memctrl sampled high.
REQ-020 On end_from_memctrl in MISS: write data, tag, valid=1 to line; next cycle enable_to_memctrl=0, end_to_fetcher=1, inst_to_fetcher=inst_from_memctrl; state -> IDLE.
REQ-021 clear_in in IDLE: no response issued for any request sampled that cycle; clear wins over simultaneous hit.
REQ-022 clear_in in MISS: state -> MISS_DISCARD; memory request continues (in-flight transfer never aborted).
REQ-023 MISS_DISCARD: on end_from_memctrl fill line normally, drop enable_to_memctrl, no end_to_fetcher pulse; -> IDLE.
REQ-024 clear_in sampled in the same cycle as end_from_memctrl in MISS: fill line, no end_to_fetcher pulse.
REQ-025 clear_in never invalidates lines.
REQ-026 end_to_fetcher never high two consecutive cycles; outputs registered.
REQ-027 enable_from_fetcher dropped during MISS: fill completes; end_to_fetcher still pulses (fetcher ignores).
REQ-028 rdy_in=0: all registers, valid bits, state and outputs hold; end_from_memctrl not sampled.
REQ-029 Line replacement: fill always overwrites indexed line regardless of prior valid/tag.

Reset
REQ-030 rst_in=1 at edge: all valid bits cleared, state IDLE, end_to_fetcher=0, inst_to_fetcher=0, enable_to_memctrl=0, address_to_memctrl=0; overrides rdy_in.
REQ-031 Reset mid-MISS: enable_to_memctrl=0 next cycle, pending fill discarded, line not written.
REQ-032 Tag/data arrays need no reset.

Verification
REQ-033 Cold miss: fetch 0x00001000, memctrl ends after 5 cycles with 0x00000013 -> enable_to_memctrl 1 for 5 cycles, addr 0x00001000, end_to_fetcher pulse with 0x00000013 one cycle after end.
REQ-034 Re-fetch 0x00001000 -> end_to_fetcher one cycle after request, data 0x00000013, enable_to_memctrl stays 0.
REQ-035 Conflict: fill 0x00001000 then fetch 0x00001100 (same index, INDEX_BITS=6) -> miss; subsequent 0x00001000 -> miss again.
REQ-036 clear_in two cycles into a miss on 0x00002004 -> request held until end_from_memctrl, no end_to_fetcher; later fetch 0x00002004 hits.
REQ-037 rdy_in low 3 cycles mid-MISS -> outputs unchanged during stall, completion shifted by 3 cycles.
REQ-038 rst_in after line 0x00001000 filled -> next fetch of 0x00001000 misses.
